// File: rtl/pu_or1k_branch_resolver_if.sv
// Push / resolve / predictor-update bundle of pu_or1k_branch_resolver.
// Defining PU_OR1K_BRANCH_STATS_EN adds the branch and mispredict statistic counters.
interface pu_or1k_branch_resolver_if #(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int QUEUE_DEPTH          = 4,
    parameter int GSHARE_BITS_NUM      = 10
);
    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

    logic                            push_i;
    logic                            push_op_bf_i;
    logic                            push_op_bnf_i;
    logic                            push_pred_flag_i;
    logic [GSHARE_BITS_NUM-1:0]      push_idx_i;
    logic [OPTION_OPERAND_WIDTH-1:0] push_pc_i;
    logic [OPTION_OPERAND_WIDTH-1:0] push_target_i;
    logic                            push_ready_o;
    logic                            resolve_i;
    logic                            flag_i;
    logic                            upd_valid_o;
    logic                            upd_taken_o;
    logic [GSHARE_BITS_NUM-1:0]      upd_idx_o;
    logic [OPTION_OPERAND_WIDTH-1:0] upd_pc_o;
    logic                            branch_mispredict_o;
    logic [OPTION_OPERAND_WIDTH-1:0] redirect_pc_o;
    logic                            flush_o;
    logic [CNT_W-1:0]                count_o;
`ifdef PU_OR1K_BRANCH_STATS_EN
    logic [31:0]                     stat_branches_o;
    logic [31:0]                     stat_mispredicts_o;
`endif

    modport master (
        output push_i, push_op_bf_i, push_op_bnf_i, push_pred_flag_i, push_idx_i,
               push_pc_i, push_target_i, resolve_i, flag_i,
        input  push_ready_o, upd_valid_o, upd_taken_o, upd_idx_o, upd_pc_o,
               branch_mispredict_o, redirect_pc_o, flush_o, count_o
`ifdef PU_OR1K_BRANCH_STATS_EN
        , input stat_branches_o, stat_mispredicts_o
`endif
    );

    modport slave (
        input  push_i, push_op_bf_i, push_op_bnf_i, push_pred_flag_i, push_idx_i,
               push_pc_i, push_target_i, resolve_i, flag_i,
        output push_ready_o, upd_valid_o, upd_taken_o, upd_idx_o, upd_pc_o,
               branch_mispredict_o, redirect_pc_o, flush_o, count_o
`ifdef PU_OR1K_BRANCH_STATS_EN
        , output stat_branches_o, stat_mispredicts_o
`endif
    );
endinterface

// File: rtl/pu_or1k_branch_resolver.sv
// Execute-stage resolver: queues in-flight l.bf/l.bnf predictions, resolves the oldest against
// the real flag, trains gshare and redirects fetch on mispredict. Optional: PU_OR1K_BRANCH_STATS_EN.
module pu_or1k_branch_resolver #(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int QUEUE_DEPTH          = 4,
    parameter int GSHARE_BITS_NUM      = 10
) (
    input logic                      clk,
    input logic                      rst,
    pu_or1k_branch_resolver_if.slave bus
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QUEUE_DEPTH);

    typedef enum logic {ST_RUN, ST_FLUSH} state_e;

    typedef struct packed {
        logic                            is_bf;
        logic                            pred_taken;
        logic [GSHARE_BITS_NUM-1:0]      idx;
        logic [OPTION_OPERAND_WIDTH-1:0] pc;
        logic [OPTION_OPERAND_WIDTH-1:0] target;
    } rec_t;

    state_e           state_q, state_d;
    rec_t             mem_q [QUEUE_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ready_q;
    rec_t             head, push_rec;
    logic             push_ok, resolve_ok, act_taken, mispredict, write_en;

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        push_rec = '{is_bf:      bus.push_op_bf_i,
                     pred_taken: (bus.push_op_bf_i && bus.push_pred_flag_i) ||
                                 (bus.push_op_bnf_i && !bus.push_pred_flag_i),
                     idx:        bus.push_idx_i,
                     pc:         bus.push_pc_i,
                     target:     bus.push_target_i};
        head       = mem_q[rd_ptr_q];
        push_ok    = bus.push_i && ready_q && (bus.push_op_bf_i ^ bus.push_op_bnf_i);
        resolve_ok = bus.resolve_i && (count_q != '0) && (state_q == ST_RUN);
        act_taken  = head.is_bf ? bus.flag_i : !bus.flag_i;
        mispredict = resolve_ok && (act_taken != head.pred_taken);
        // A push in the mispredicting cycle belongs to the wrong path and is discarded.
        write_en   = push_ok && !mispredict;

        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        case (state_q)
            ST_RUN: begin
                if (mispredict) begin
                    state_d  = ST_FLUSH;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    count_d  = '0;
                end else begin
                    if (write_en)   wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    if (resolve_ok) rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    count_d = count_q + CNT_W'(write_en) - CNT_W'(resolve_ok);
                end
            end
            ST_FLUSH: begin
                state_d  = ST_RUN;
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                count_d  = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q                 <= ST_RUN;
            wr_ptr_q                <= '0;
            rd_ptr_q                <= '0;
            count_q                 <= '0;
            ready_q                 <= 1'b0;
            bus.upd_valid_o         <= 1'b0;
            bus.upd_taken_o         <= 1'b0;
            bus.upd_idx_o           <= '0;
            bus.upd_pc_o            <= '0;
            bus.branch_mispredict_o <= 1'b0;
            bus.flush_o             <= 1'b0;
            bus.redirect_pc_o       <= '0;
        end else begin
            state_q                 <= state_d;
            wr_ptr_q                <= wr_ptr_d;
            rd_ptr_q                <= rd_ptr_d;
            count_q                 <= count_d;
            ready_q                 <= (state_d == ST_RUN) && (count_d != FULL_CNT);
            bus.upd_valid_o         <= resolve_ok;
            bus.upd_taken_o         <= resolve_ok && act_taken;
            bus.upd_idx_o           <= resolve_ok ? head.idx : '0;
            bus.upd_pc_o            <= resolve_ok ? head.pc : '0;
            bus.branch_mispredict_o <= mispredict;
            bus.flush_o             <= mispredict;
            // Not-taken resumes after the delay slot.
            bus.redirect_pc_o       <= !mispredict ? '0 :
                                       act_taken ? head.target :
                                       head.pc + OPTION_OPERAND_WIDTH'(8);
        end
    end

    // NOTE: record storage has no reset; the pointers and count alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (write_en) mem_q[wr_ptr_q] <= push_rec;
    end

    assign bus.push_ready_o = ready_q;
    assign bus.count_o      = count_q;

`ifdef PU_OR1K_BRANCH_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.stat_branches_o    <= '0;
            bus.stat_mispredicts_o <= '0;
        end else begin
            if (resolve_ok && (bus.stat_branches_o != '1))
                bus.stat_branches_o <= bus.stat_branches_o + 32'd1;
            if (mispredict && (bus.stat_mispredicts_o != '1))
                bus.stat_mispredicts_o <= bus.stat_mispredicts_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pu_or1k_branch_resolver.sv
// Bench for pu_or1k_branch_resolver: directed vector table, hand-written reset/stat sequences,
// and random traffic checked against a queue-based reference model.
module tb_pu_or1k_branch_resolver;
    localparam int W = 32;
    localparam int D = 4;
    localparam int G = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;

    pu_or1k_branch_resolver_if #(.OPTION_OPERAND_WIDTH(W), .QUEUE_DEPTH(D), .GSHARE_BITS_NUM(G)) bus ();

    pu_or1k_branch_resolver #(.OPTION_OPERAND_WIDTH(W), .QUEUE_DEPTH(D), .GSHARE_BITS_NUM(G)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         push, bf, bnf, pf;
        bit [G-1:0] idx;
        bit [W-1:0] pc, tgt;
        bit         res, flag;
    } stim_t;

    typedef struct {
        stim_t      s;
        int         cnt;
        bit         rdy, uv, ut, mis;
        bit [W-1:0] rpc, upc;
        bit [G-1:0] uidx;
    } vec_t;

    typedef struct {
        bit         bf, bnf, pf;
        bit [G-1:0] idx;
        bit [W-1:0] pc, tgt;
    } mrec_t;

    int          n_cmp  = 0;
    int          n_fail = 0;
    mrec_t       mq[$];
    bit          m_flushing = 1'b0;
    bit          m_ready    = 1'b0;
    int unsigned m_br  = 0;
    int unsigned m_mis = 0;
    bit          e_uv, e_ut, e_mis;
    bit [W-1:0]  e_rpc, e_upc;
    bit [G-1:0]  e_uidx;
    vec_t        vq[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t st(bit push, bit bf, bit bnf, bit pf, int idx, bit [W-1:0] pc,
                                 bit [W-1:0] tgt, bit res, bit flag);
        stim_t s;
        s.push = push; s.bf = bf; s.bnf = bnf; s.pf = pf; s.idx = G'(idx);
        s.pc = pc; s.tgt = tgt; s.res = res; s.flag = flag;
        return s;
    endfunction

    function automatic stim_t idle();
        return st(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic vec_t mk(stim_t s, int cnt, bit rdy, bit uv, bit ut, bit mis,
                                bit [W-1:0] rpc, bit [W-1:0] upc, int uidx);
        vec_t v;
        v.s = s; v.cnt = cnt; v.rdy = rdy; v.uv = uv; v.ut = ut; v.mis = mis;
        v.rpc = rpc; v.upc = upc; v.uidx = G'(uidx);
        return v;
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_flushing = 1'b0;
        m_ready    = 1'b0;
        m_br       = 0;
        m_mis      = 0;
    endfunction

    // Drive one cycle of stimulus, advance the reference model, compare after the edge.
    task automatic cycle(input stim_t s);
        bit    res_ok, push_ok, at, pt;
        mrec_t r;
        bus.push_i           = s.push;
        bus.push_op_bf_i     = s.bf;
        bus.push_op_bnf_i    = s.bnf;
        bus.push_pred_flag_i = s.pf;
        bus.push_idx_i       = s.idx;
        bus.push_pc_i        = s.pc;
        bus.push_target_i    = s.tgt;
        bus.resolve_i        = s.res;
        bus.flag_i           = s.flag;

        e_uv = 0; e_ut = 0; e_mis = 0; e_rpc = '0; e_upc = '0; e_uidx = '0;
        res_ok  = s.res && (mq.size() > 0) && !m_flushing;
        push_ok = s.push && m_ready && (s.bf != s.bnf);
        if (res_ok) begin
            r      = mq[0];
            at     = (r.bf && s.flag) || (r.bnf && !s.flag);
            pt     = (r.bf && r.pf) || (r.bnf && !r.pf);
            e_uv   = 1;
            e_ut   = at;
            e_upc  = r.pc;
            e_uidx = r.idx;
            e_mis  = (at != pt);
            if (e_mis) e_rpc = at ? r.tgt : r.pc + 32'd8;
            m_br++;
            if (e_mis) m_mis++;
        end
        if (e_mis) begin
            mq.delete();
            m_flushing = 1'b1;
        end else begin
            m_flushing = 1'b0;
            if (res_ok)  void'(mq.pop_front());
            if (push_ok) mq.push_back('{s.bf, s.bnf, s.pf, s.idx, s.pc, s.tgt});
        end
        m_ready = !m_flushing && (mq.size() < D);

        @(posedge clk);
        #1;
        check("count", 64'(bus.count_o), 64'(mq.size()));
        check("push_ready", 64'(bus.push_ready_o), 64'(m_ready));
        check("upd_valid", 64'(bus.upd_valid_o), 64'(e_uv));
        check("mispredict", 64'(bus.branch_mispredict_o), 64'(e_mis));
        check("flush", 64'(bus.flush_o), 64'(e_mis));
        if (e_uv) begin
            check("upd_taken", 64'(bus.upd_taken_o), 64'(e_ut));
            check("upd_idx", 64'(bus.upd_idx_o), 64'(e_uidx));
            check("upd_pc", 64'(bus.upd_pc_o), 64'(e_upc));
        end
        if (e_mis) check("redirect_pc", 64'(bus.redirect_pc_o), 64'(e_rpc));
    endtask

    initial begin
        vq.push_back(mk(st(1,1,0,1,5,'h100,'h200,0,0), 1,1, 0,0,0, 0,0,0));
        vq.push_back(mk(st(0,0,0,0,0,0,0,1,1),         0,1, 1,1,0, 0,'h100,5));
        vq.push_back(mk(st(1,0,1,0,7,'h300,'h400,0,0), 1,1, 0,0,0, 0,0,0));
        vq.push_back(mk(st(0,0,0,0,0,0,0,1,1),         0,0, 1,0,1, 'h308,'h300,7));
        vq.push_back(mk(idle(),                        0,1, 0,0,0, 0,0,0));
        vq.push_back(mk(st(1,1,0,1,1,'h1000,'h1100,0,0), 1,1, 0,0,0, 0,0,0));
        vq.push_back(mk(st(1,1,0,1,2,'h1010,'h1110,0,0), 2,1, 0,0,0, 0,0,0));
        vq.push_back(mk(st(1,1,0,1,3,'h1020,'h1120,0,0), 3,1, 0,0,0, 0,0,0));
        vq.push_back(mk(st(1,1,0,1,4,'h1030,'h1130,0,0), 4,0, 0,0,0, 0,0,0));
        vq.push_back(mk(st(1,1,0,1,9,'h1040,'h1140,0,0), 4,0, 0,0,0, 0,0,0));
        vq.push_back(mk(st(1,1,0,1,9,'h1040,'h1140,1,1), 3,1, 1,1,0, 0,'h1000,1));
        vq.push_back(mk(st(1,1,0,1,6,'h1050,'h1150,1,1), 3,1, 1,1,0, 0,'h1010,2));
        vq.push_back(mk(st(0,0,0,0,0,0,0,1,1),           2,1, 1,1,0, 0,'h1020,3));
        vq.push_back(mk(st(0,0,0,0,0,0,0,1,1),           1,1, 1,1,0, 0,'h1030,4));
        vq.push_back(mk(st(0,0,0,0,0,0,0,1,1),           0,1, 1,1,0, 0,'h1050,6));
        vq.push_back(mk(st(0,0,0,0,0,0,0,1,1),           0,1, 0,0,0, 0,0,0));
        vq.push_back(mk(st(1,1,1,1,8,'h1800,'h1900,0,0), 0,1, 0,0,0, 0,0,0));
        vq.push_back(mk(st(1,0,0,1,8,'h1800,'h1900,0,0), 0,1, 0,0,0, 0,0,0));
        vq.push_back(mk(st(1,1,0,1,'h3FF,'h2000,'h2400,0,0), 1,1, 0,0,0, 0,0,0));
        vq.push_back(mk(st(1,1,0,1,'h12,'h3000,'h3400,1,0),  0,0, 1,0,1, 'h2008,'h2000,'h3FF));
        vq.push_back(mk(st(1,1,0,1,'h13,'h3100,'h3500,1,1),  0,1, 0,0,0, 0,0,0));
        vq.push_back(mk(st(1,0,1,0,'h55,'hFFFF_FFFC,'h40,0,0), 1,1, 0,0,0, 0,0,0));
        vq.push_back(mk(st(0,0,0,0,0,0,0,1,1),               0,0, 1,0,1, 'h4,'hFFFF_FFFC,'h55));
        vq.push_back(mk(st(1,0,1,1,'h11,'h500,'h600,0,0),    0,1, 0,0,0, 0,0,0));
        vq.push_back(mk(st(1,0,1,1,'h11,'h500,'h600,0,0),    1,1, 0,0,0, 0,0,0));
        vq.push_back(mk(st(0,0,0,0,0,0,0,1,0),               0,0, 1,1,1, 'h600,'h500,'h11));
        vq.push_back(mk(idle(),                              0,1, 0,0,0, 0,0,0));
        vq.push_back(mk(st(1,1,0,0,'h21,'h700,'h780,0,0),    1,1, 0,0,0, 0,0,0));
        vq.push_back(mk(st(1,1,0,1,'h22,'h710,'h790,0,0),    2,1, 0,0,0, 0,0,0));
        vq.push_back(mk(st(0,0,0,0,0,0,0,1,1),               0,0, 1,1,1, 'h780,'h700,'h21));
        vq.push_back(mk(idle(),                              0,1, 0,0,0, 0,0,0));
        vq.push_back(mk(st(0,0,0,0,0,0,0,1,1),               0,1, 0,0,0, 0,0,0));

        void'(idle());
        bus.push_i = 0; bus.push_op_bf_i = 0; bus.push_op_bnf_i = 0; bus.push_pred_flag_i = 0;
        bus.push_idx_i = '0; bus.push_pc_i = '0; bus.push_target_i = '0;
        bus.resolve_i = 0; bus.flag_i = 0;
        model_reset();

        // Reset state.
        #12;
        check("rst_count", 64'(bus.count_o), 64'd0);
        check("rst_upd_valid", 64'(bus.upd_valid_o), 64'd0);
        check("rst_mispredict", 64'(bus.branch_mispredict_o), 64'd0);
        check("rst_flush", 64'(bus.flush_o), 64'd0);
        check("rst_redirect", 64'(bus.redirect_pc_o), 64'd0);
        rst = 1'b1;
        cycle(idle());
        cycle(idle());
        check("ready_after_rst", 64'(bus.push_ready_o), 64'd1);

        // Directed vector table.
        foreach (vq[i]) begin
            cycle(vq[i].s);
            check($sformatf("vec%0d_count", i), 64'(bus.count_o), 64'(vq[i].cnt));
            check($sformatf("vec%0d_ready", i), 64'(bus.push_ready_o), 64'(vq[i].rdy));
            check($sformatf("vec%0d_uv", i), 64'(bus.upd_valid_o), 64'(vq[i].uv));
            check($sformatf("vec%0d_mis", i), 64'(bus.branch_mispredict_o), 64'(vq[i].mis));
            if (vq[i].uv) begin
                check($sformatf("vec%0d_ut", i), 64'(bus.upd_taken_o), 64'(vq[i].ut));
                check($sformatf("vec%0d_upc", i), 64'(bus.upd_pc_o), 64'(vq[i].upc));
                check($sformatf("vec%0d_uidx", i), 64'(bus.upd_idx_o), 64'(vq[i].uidx));
            end
            if (vq[i].mis) check($sformatf("vec%0d_rpc", i), 64'(bus.redirect_pc_o), 64'(vq[i].rpc));
        end

        // Asynchronous reset with three records pending and a resolve requested.
        cycle(st(1,1,0,1,1,'h4000,'h4100,0,0));
        cycle(st(1,0,1,0,2,'h4010,'h4110,0,0));
        cycle(st(1,1,0,1,3,'h4020,'h4120,0,0));
        check("pre_rst_count", 64'(bus.count_o), 64'd3);
        bus.push_i = 0; bus.resolve_i = 1; bus.flag_i = 1;
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_count", 64'(bus.count_o), 64'd0);
        check("async_rst_uv", 64'(bus.upd_valid_o), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        check("rst_hold_uv", 64'(bus.upd_valid_o), 64'd0);
        check("rst_hold_ready", 64'(bus.push_ready_o), 64'd0);
        bus.resolve_i = 0;
        rst = 1'b1;
        cycle(idle());
        cycle(idle());

        // Three resolves, one mispredict.
        cycle(st(1,1,0,1,1,'h5000,'h5100,0,0));
        cycle(st(0,0,0,0,0,0,0,1,1));
        cycle(st(1,0,1,0,2,'h5010,'h5110,0,0));
        cycle(st(0,0,0,0,0,0,0,1,0));
        cycle(st(1,1,0,1,3,'h5020,'h5120,0,0));
        cycle(st(0,0,0,0,0,0,0,1,0));
        cycle(idle());
`ifdef PU_OR1K_BRANCH_STATS_EN
        check("stat_branches", 64'(bus.stat_branches_o), 64'd3);
        check("stat_mispredicts", 64'(bus.stat_mispredicts_o), 64'd1);
`endif

        // Random traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            stim_t s;
            int    op;
            op     = int'($urandom_range(0, 9));
            s.push = ($urandom_range(0, 99) < 55);
            s.bf   = (op == 0) || (op >= 2 && op < 6);
            s.bnf  = (op == 0) || (op >= 6);
            s.pf   = 1'($urandom);
            s.idx  = G'($urandom);
            s.pc   = W'($urandom) & ~32'h3;
            s.tgt  = W'($urandom) & ~32'h3;
            s.res  = ($urandom_range(0, 99) < 45);
            s.flag = 1'($urandom);
            cycle(s);
        end
`ifdef PU_OR1K_BRANCH_STATS_EN
        check("stat_branches_final", 64'(bus.stat_branches_o), 64'(m_br));
        check("stat_mispredicts_final", 64'(bus.stat_mispredicts_o), 64'(m_mis));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/pu_or1k_branch_resolver.md
Name: pu_or1k_branch_resolver

Overview:
- Execute-stage counterpart of the gshare predictor: holds in-flight conditional-branch predictions and resolves each against the real flag.
- Raises mispredict/redirect to fetch and emits the one-cycle update stream the predictor consumes (prev_op_brcond, brn_taken, brn_pc).
- Sits between decode (push side) and execute/fetch control (resolve/redirect side).

Parameters:
OPTION_OPERAND_WIDTH, 32, PC/target width
QUEUE_DEPTH, 4, in-flight branch records; power of 2, >=2
GSHARE_BITS_NUM, 10, width of stored predictor index returned on update

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
push_i  in  1  decode pushes a conditional-branch record
push_op_bf_i  in  1  branch is l.bf
push_op_bnf_i  in  1  branch is l.bnf
push_pred_flag_i  in  1  predicted flag from predictor
push_idx_i  in  GSHARE_BITS_NUM  predictor table index used
push_pc_i  in  OPTION_OPERAND_WIDTH  branch PC
push_target_i  in  OPTION_OPERAND_WIDTH  taken target
push_ready_o  out  1  record can be accepted
resolve_i  in  1  oldest branch resolves this cycle
flag_i  in  1  architectural flag at resolution
upd_valid_o  out  1  predictor update pulse (prev_op_brcond)
upd_taken_o  out  1  actual direction (brn_taken)
upd_idx_o  out  GSHARE_BITS_NUM  index to train
upd_pc_o  out  OPTION_OPERAND_WIDTH  resolved branch PC
branch_mispredict_o  out  1  mispredict pulse
redirect_pc_o  out  OPTION_OPERAND_WIDTH  correct fetch PC, valid with mispredict
flush_o  out  1  younger in-flight state discarded
count_o  out  clog2(QUEUE_DEPTH)+1  occupancy

Behaviour:
- Reset (rst=0, async): queue empty, count_o=0, state RUN, all outputs 0, push_ready_o=1 after release.
- Queue: circular FIFO, read/write pointers wrap modulo QUEUE_DEPTH; push_ready_o = (state==RUN) && !full, from registers only.
- Push accepted when push_i && push_ready_o; push while not ready silently dropped. Record with neither or both op bits set is dropped.
- Predicted direction pt = (bf&&pred_flag)||(bnf&&!pred_flag); actual at = (bf&&flag_i)||(bnf&&!flag_i).
- Resolve accepted when resolve_i && count>0 && state==RUN; pops head. Resolve on empty queue or in FLUSH is ignored (no outputs).
- Latency 1: cycle after accepted resolve, upd_valid_o=1, upd_taken_o=at, upd_idx_o/upd_pc_o from record; all output pulses one cycle wide.
- at!=pt: same cycle branch_mispredict_o=1, flush_o=1; redirect_pc_o = target if at, else pc+8 (delay slot), mod 2^W.
- Simultaneous push and resolve: both take effect, count unchanged; allowed when full (push_ready_o is 0 when full, so push is dropped when full).
- FSM: RUN -> FLUSH on mispredicting resolve; FLUSH lasts exactly 1 cycle: pointers and count cleared, push_ready_o=0, pushes dropped including any push in the mispredicting cycle; FLUSH -> RUN.
- Correct predictions never leave RUN.
- Reset asserted mid-FLUSH or with pending records: all discarded immediately, no update pulse.

Optional Feature:
- PU_OR1K_BRANCH_STATS_EN defined: adds outputs stat_branches_o and stat_mispredicts_o (32 bits each), incremented on each accepted resolve / mispredict, saturating at 0xFFFFFFFF, cleared by reset.
- Undefined: counters and ports absent, behaviour otherwise identical.

Test Plan:
- Reset, push bf pc=0x100 tgt=0x200 pred_flag=1, resolve flag=1 -> next cycle upd_valid=1, upd_taken=1, mispredict=0, count 1->0.
- Push bnf pc=0x300 tgt=0x400 pred_flag=0, resolve flag=1 -> mispredict=1, flush=1, redirect=0x308, upd_taken=0; next cycle push_ready=0, count=0.
- Push 4 records (depth 4) -> push_ready=0, 5th push dropped; then 4 correct resolves -> 4 update pulses in push order, pc/idx match.
- Full queue, push and resolve same cycle -> push dropped, count 4->3; non-full, push and resolve same cycle -> count unchanged.
- Resolve with empty queue -> no pulses; assert rst low with 3 records queued -> count_o=0 asynchronously, no upd_valid.
- With PU_OR1K_BRANCH_STATS_EN: 3 resolves, 1 mispredict -> stat_branches=3, stat_mispredicts=1.
